// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch/decode handshake bundle for the instruction prefetch queue
interface inst_fetch_queue_if #(
    parameter int PTR_W = 2
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic [PTR_W:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - circular {PC, instruction} prefetch FIFO with flush; IFQ_BYPASS_EN adds empty-queue bypass
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inst_fetch_queue_if.slave      q
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]    NOP_INST = 32'h0000_0013;

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;

    always_comb begin
        empty = (cnt == '0);
        full  = (cnt == FULL_CNT);
`ifdef IFQ_BYPASS_EN
        bypass = empty & q.in_valid & ~q.flush;
`else
        bypass = 1'b0;
`endif
        q.in_ready  = ~full & ~q.flush;
        q.out_valid = (~empty | bypass) & ~q.flush;
        q.count     = cnt;

        if (!empty) begin
            q.out_pc   = pc_mem[rd_ptr];
            q.out_inst = inst_mem[rd_ptr];
        end else if (bypass) begin
            q.out_pc   = q.in_pc;
            q.out_inst = q.in_inst;
        end else begin
            q.out_pc   = 32'h0;
            q.out_inst = NOP_INST;
        end

        // A bypassed pair consumed straight away never touches storage.
        pop  = ~empty & q.out_valid & q.out_ready;
        push = q.in_valid & q.in_ready & ~(bypass & q.out_ready);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= q.in_pc;
            inst_mem[wr_ptr] <= q.in_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + (PTR_W + 1)'(1);
                2'b01:   cnt <= cnt - (PTR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - vector table, bypass/reset sequences and randomized model check for inst_fetch_queue
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.PTR_W(PTR_W)) q ();

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        chk_out;
        logic        ir;
        logic        ov;
        logic [31:0] opc;
        int          cnt;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] mq[$];
    logic [31:0] rx[$];
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic fl, iv, input logic [31:0] pc, input logic ordy, chk_out, ir, ov,
                       input logic [31:0] opc, input int cnt);
        vec_t v;
        v = '{fl, iv, pc, ordy, chk_out, ir, ov, opc, cnt};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic fl, iv, input logic [31:0] pc, input logic ordy);
        q.flush     = fl;
        q.in_valid  = iv;
        q.in_pc     = pc;
        q.in_inst   = pc | 32'h13;
        q.out_ready = ordy;
    endtask

    // Reference: a plain queue of pairs; outputs are derived from its size and head.
    task automatic model_step(input string tag);
        int          n;
        logic        byp, e_ir, e_ov, take;
        logic [63:0] head;
        n = mq.size();
`ifdef IFQ_BYPASS_EN
        byp = (n == 0) && q.in_valid && !q.flush;
`else
        byp = 1'b0;
`endif
        e_ir = (n != DEPTH) && !q.flush;
        e_ov = !q.flush && (n != 0 || byp);
        head = (n != 0) ? mq[0] : byp ? {q.in_pc, q.in_inst} : {32'h0, 32'h13};
        chk({tag, "_count"}, 32'(q.count), 32'(n));
        chk({tag, "_in_ready"}, 32'(q.in_ready), 32'(e_ir));
        chk({tag, "_out_valid"}, 32'(q.out_valid), 32'(e_ov));
        if (e_ov || n == 0) begin
            chk({tag, "_out_pc"}, q.out_pc, head[63:32]);
            chk({tag, "_out_inst"}, q.out_inst, head[31:0]);
        end
        if (q.flush) begin
            mq.delete();
        end else begin
            take = e_ov && q.out_ready;
            if (take) rx.push_back(head[63:32]);
            if (take && n != 0) void'(mq.pop_front());
            if (q.in_valid && e_ir && !(take && n == 0)) mq.push_back({q.in_pc, q.in_inst});
        end
    endtask

    initial begin
        int sent;
        int cyc;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_count", 32'(q.count), 32'd0);
        chk("reset_out_valid", 32'(q.out_valid), 32'd0);
        chk("reset_in_ready", 32'(q.in_ready), 32'd1);
        chk("reset_out_pc", q.out_pc, 32'h0);
        chk("reset_out_inst", q.out_inst, 32'h13);
        rst_n = 1'b1;

        //  fl  iv  pc      ordy chk ir  ov  opc     cnt
        add(0, 1, 32'h00, 0, 0, 1, 0, 32'h00, 0);
        add(0, 1, 32'h04, 0, 1, 1, 1, 32'h00, 1);
        add(0, 1, 32'h08, 0, 1, 1, 1, 32'h00, 2);
        add(0, 1, 32'h0C, 0, 1, 1, 1, 32'h00, 3);
        add(0, 1, 32'h10, 0, 1, 0, 1, 32'h00, 4);
        add(0, 1, 32'h10, 1, 1, 0, 1, 32'h00, 4);
        add(0, 1, 32'h10, 0, 1, 1, 1, 32'h04, 3);
        add(0, 0, 32'h00, 1, 1, 0, 1, 32'h04, 4);
        add(0, 0, 32'h00, 1, 1, 1, 1, 32'h08, 3);
        add(0, 1, 32'h14, 1, 1, 1, 1, 32'h0C, 2);
        add(0, 1, 32'h18, 1, 1, 1, 1, 32'h10, 2);
        add(0, 1, 32'h1C, 0, 1, 1, 1, 32'h14, 2);
        add(1, 1, 32'h20, 1, 1, 0, 0, 32'h00, 3);
        add(0, 0, 32'h00, 0, 1, 1, 0, 32'h00, 0);
        add(1, 1, 32'h44, 1, 1, 0, 0, 32'h00, 0);
        add(1, 1, 32'h48, 1, 1, 0, 0, 32'h00, 0);
        add(0, 0, 32'h00, 0, 1, 1, 0, 32'h00, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d_count", i), 32'(q.count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_in_ready", i), 32'(q.in_ready), 32'(tbl[i].ir));
            if (tbl[i].chk_out) begin
                chk($sformatf("vec%0d_out_valid", i), 32'(q.out_valid), 32'(tbl[i].ov));
                if (tbl[i].ov) begin
                    chk($sformatf("vec%0d_out_pc", i), q.out_pc, tbl[i].opc);
                    chk($sformatf("vec%0d_out_inst", i), q.out_inst, tbl[i].opc | 32'h13);
                end
            end
        end

        // Empty queue presented with a pair that decode is ready to take.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h40, 1'b1);
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_same_valid", 32'(q.out_valid), 32'd1);
        chk("byp_same_pc", q.out_pc, 32'h40);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("byp_next_count", 32'(q.count), 32'd0);
        chk("byp_next_valid", 32'(q.out_valid), 32'd0);
`else
        chk("nobyp_same_valid", 32'(q.out_valid), 32'd0);
        chk("nobyp_same_pc", q.out_pc, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("nobyp_next_count", 32'(q.count), 32'd1);
        chk("nobyp_next_valid", 32'(q.out_valid), 32'd1);
        chk("nobyp_next_pc", q.out_pc, 32'h40);
        chk("nobyp_next_inst", q.out_inst, 32'h53);
`endif
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("byp_drain_count", 32'(q.count), 32'd0);

        // Ten-pair stream with random decode back-pressure across pointer wrap.
        mq.delete();
        rx.delete();
        sent = 0;
        cyc = 0;
        while ((sent < 10 || mq.size() != 0) && cyc < 500) begin
            @(negedge clk);
            drive(1'b0, (sent < 10) && ($urandom_range(3) != 0), 32'(sent * 4), 1'($urandom_range(1)));
            #1;
            if (q.in_valid && q.in_ready) sent++;
            model_step("stream");
            cyc++;
        end
        chk("stream_timeout", 32'(cyc < 500), 32'd1);
        chk("stream_rx_size", 32'(rx.size()), 32'd10);
        for (int i = 0; i < 10 && i < rx.size(); i++)
            chk($sformatf("stream_rx%0d", i), rx[i], 32'(i * 4));

        // Free-running traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(($urandom_range(15) == 0), 1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(1)));
            #1;
            model_step("rand");
        end

        // Asynchronous reset in the middle of a cycle with entries queued.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h80, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(q.count), 32'd0);
        chk("midrst_out_valid", 32'(q.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(q.in_ready), 32'd1);
        chk("midrst_out_inst", q.out_inst, 32'h13);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
